// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge
//   Command parser and register bank between SPI_Slave and the control logic.
//   Each chip-select frame carries one command byte followed by a read or
//   write burst.
//   Command byte: bit 7 = W (1 write / 0 read), bit 6 = INC (auto-increment),
//   bits [3:0] = start address, bits [5:4] ignored.
//
// Ports
//   clk        system clock (shared with SPI_Slave)
//   rst_n      asynchronous active-low reset
//   spi_cs_n   raw chip select, synchronized internally (2 flops)
//   rx_data    received byte, qualified by rx_valid
//   rx_valid   one-cycle pulse per received byte
//   tx_req     one-cycle pulse; the slave latches tx_data in this cycle
//   tx_data    next byte to shift out
//   regs_out   flat register bus, reg[i] at bits [8i+7:8i]
//   wr_strobe  one-cycle pulse per register write
//   wr_addr    address of the last write, valid with wr_strobe
module spi_reg_bridge #(
  parameter int         DATA_WIDTH = 8,
  parameter int         NUM_REGS   = 16,
  parameter logic [7:0] HDR_BYTE   = 8'hA5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           spi_cs_n,
  input  logic [DATA_WIDTH-1:0]          rx_data,
  input  logic                           rx_valid,
  input  logic                           tx_req,
  output logic [DATA_WIDTH-1:0]          tx_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic                           wr_strobe,
  output logic [3:0]                     wr_addr
);

  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

  localparam logic [3:0] LAST_ADDR = 4'(NUM_REGS - 1);

  state_t                state;
  logic                  cs_meta;
  logic                  cs_sync;
  logic [3:0]            addr;
  logic                  inc;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Advance with wrap; an out-of-range address also wraps to 0.
  function automatic logic [3:0] next_addr(input logic [3:0] a);
    return (a >= LAST_ADDR) ? 4'd0 : a + 4'd1;
  endfunction

  function automatic logic in_range(input logic [3:0] a);
    return {1'b0, a} < 5'(NUM_REGS);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] reg_rd(input logic [3:0] a);
    return in_range(a) ? regs[a] : '0;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta <= 1'b1;
      cs_sync <= 1'b1;
    end else begin
      cs_meta <= spi_cs_n;
      cs_sync <= cs_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      inc       <= 1'b0;
      tx_data   <= HDR_BYTE;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      case (state)
        IDLE: begin
          tx_data <= HDR_BYTE;
          if (!cs_sync) state <= CMD;
        end
        CMD: begin
          if (rx_valid) begin
            addr <= rx_data[3:0];
            inc  <= rx_data[6];
            if (rx_data[7]) begin
              state   <= WRITE;
              tx_data <= rx_data;
            end else begin
              state   <= READ;
              tx_data <= reg_rd(rx_data[3:0]);
            end
          end
        end
        WRITE: begin
          if (rx_valid) begin
            if (in_range(addr)) begin
              regs[addr] <= rx_data;
              wr_strobe  <= 1'b1;
              wr_addr    <= addr;
            end
            tx_data <= rx_data;
            if (inc) addr <= next_addr(addr);
          end
        end
        READ: begin
          if (tx_req) begin
            if (inc) addr <= next_addr(addr);
            tx_data <= reg_rd(inc ? next_addr(addr) : addr);
          end
        end
        default: state <= IDLE;
      endcase
      // Frame end overrides the state update above, but a byte arriving in the
      // same cycle has already been processed (write committed).
      if (cs_sync && state != IDLE) begin
        state   <= IDLE;
        tx_data <= HDR_BYTE;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: doc/spi_reg_bridge.md
# spi_reg_bridge

Command parser and register bank that consumes the byte stream from `SPI_Slave` (`rx_data`/`rx_valid`) and supplies its transmit byte (`tx_data` on `tx_req`). It replaces the plain loopback register in the SPI top, turning each chip-select frame into a register read or write burst. Control logic elsewhere in the design sees the registers on a flat output bus, plus a write strobe for each update.

## Interface
- `DATA_WIDTH`, 8: byte width. Only 8 is supported.
- `NUM_REGS`, 16: number of registers, 2..16.
- `HDR_BYTE`, 8'hA5: byte returned during the command byte.

- `clk` in 1: system clock. Same clock as `SPI_Slave`.
- `rst_n` in 1: asynchronous, active-low reset.
- `spi_cs_n` in 1: raw SPI chip select. Synchronized internally with a 2-FF chain.
- `rx_data` in 8: received byte from the slave. Valid when `rx_valid`=1.
- `rx_valid` in 1: one-cycle pulse per received byte.
- `tx_req` in 1: one-cycle pulse. The slave latches `tx_data` in this cycle.
- `tx_data` out 8: next byte to shift out.
- `regs_out` out NUM_REGS*8: register contents. reg[i] is at bits [8i+7:8i].
- `wr_strobe` out 1: one-cycle pulse when a register is written.
- `wr_addr` out 4: address of the last write. Valid with `wr_strobe`.

## Operation
- Command byte, bit 7 = W (1 = write, 0 = read).
- Command byte, bit 6 = INC (1 = auto-increment address).
- Command byte, bits[3:0] = start address. Bits [5:4] are ignored.
- State machine states: IDLE, CMD, WRITE, READ.
  - IDLE→CMD: synchronized `cs_n` goes low.
  - CMD→WRITE: `rx_valid` arrives with W=1. Latches addr and INC.
  - CMD→READ: `rx_valid` arrives with W=0. Latches addr and INC.
  - Any state→IDLE: synchronized `cs_n` goes high.
- WRITE: each `rx_valid` writes `rx_data` to reg[addr] and pulses `wr_strobe` with `wr_addr`=addr. If INC=1, addr then advances.
- READ: each `tx_req` is followed by an address advance if INC=1. `tx_data` then reloads reg[new addr].
- Address advance: addr+1, wrapping from NUM_REGS-1 to 0.
- Out-of-range addr (≥NUM_REGS, only possible with a start addr): writes are dropped, with no `wr_strobe`. Reads return 8'h00. Incrementing from an out-of-range addr wraps to 0.
- `tx_data` by state:
  - IDLE and CMD: HDR_BYTE.
  - READ: reg[addr].
  - WRITE: last byte written in this frame (echo). Before any data byte it is the command byte.
- `rx_valid` in IDLE is ignored.
- `tx_req` in IDLE, CMD or WRITE does not change state.

## Timing
- Reset values:
  - state=IDLE, all regs=0, `regs_out`=0.
  - `tx_data`=HDR_BYTE, `wr_strobe`=0, `wr_addr`=0.
  - Synchronizer flops reset to 1.
- All outputs are registered.
- `wr_strobe` and `regs_out` update on the cycle after `rx_valid` (latency 1).
- `tx_data` is valid 1 cycle after the `rx_valid` of the command byte and 1 cycle after each READ `tx_req`. The slave guarantees at least 2 clk between a byte's `rx_valid` and the next `tx_req`.
- `cs_n` edges take effect 2 cycles after the pin changes (synchronizer). The frame boundary is seen 3 cycles after the pin edge.
- `rx_valid` in the same cycle as the synchronized `cs_n` rise: the byte is processed (write or command) first, and the state is IDLE next cycle.
- `cs_n` rising mid-burst: the registers keep every completed write. No partial writes are possible.
- `rst_n` asserted mid-frame: everything returns to reset values immediately, including regs.
- A new frame always restarts at CMD. The address does not persist across frames.

## Test plan
- Reset: check every output; `regs_out`=0 and `tx_data`=8'hA5.
- Write burst: frame with cmd 8'hC2 then data 11, 22, 33. Required: reg2=11, reg3=22, reg4=33. Three `wr_strobe` pulses with `wr_addr` 2, 3, 4. `tx_data` echoes C2, 11, 22.
- Wrap on read: preload reg15=0x5F and reg0=0x60. Frame with cmd 8'h4F and 3 dummy bytes. Required MISO bytes: A5, 5F, 60, reg1.
- No increment: write cmd 8'h85 then 01, 02. Required: reg5=02 and two strobes at addr 5. Then a read with cmd 8'h05 and 2 dummy bytes returns A5, 02, 02.
- Frame abort: raise `cs_n` after 1 of 2 write data bytes. Required: first byte written, state IDLE. The next frame's first MISO byte is A5.
- Reset mid-read: assert `rst_n` low during READ. Required: regs cleared, `tx_data`=A5, state IDLE. After release, a new write of 0x77 to addr 0 succeeds.
